dual_issue_decoder: RTL and testbench
=====================================

// Module: dual_issue_decoder
// PURPOSE
//  Two-slot (A = older, B = younger) RV32I decode stage of the dual-issue pipeline.
//  Extracts register addresses for regfile/rename, selects operand sources, and
//  emits one registered 83-bit decoded word per slot for dispatch.
//  Selects each operand from: regfile data, the single writeback forwarding bus, or immediate/PC.
// PARAMETERS
//  none (field layout and encodings are fixed constants in decoder_pkg)
// PORTS
//  clk                clk    1   single clock, rising edge
//  rst                in     1   synchronous reset, active-high
//  instA, instB       in     32  raw instructions
//  pcA, pcB           in     32  instruction PCs
//  forwarding         in     32  writeback result bus
//  forwarding_addr    in     5   destination register of forwarding
//  s1A,s2A,s1B,s2B    in     32  regfile read data for rs1A/rs2A/rs1B/rs2B
//  rs1A_valid..rs2B_valid in 1   regfile value is up to date
//  decoded_instA/B    out    83  registered decoded word
//  map_en_A, map_en_B out    1   rename-map allocate (combinational)
//  rs1A,rs2A,rs1B,rs2B out   5   source register addresses (combinational)
//  rdA, rdB           out    5   destination addresses (combinational)
//  error_A, error_B   out    1   registered illegal/unsupported instruction flag
// BEHAVIOUR
//  Decoded word: [82]valid [81:80]fu(0 ALU,1 MEM) [79:76]alu_op [75]reg_we [74]mem_re
//   [73]mem_we(always 0) [72:70]funct3 [69:65]rd [64:33]op1 [32:1]op2 [0]ops_ready.
//  Supported: OP, OP-IMM, LUI, AUIPC, LOAD(funct3 0,1,2,4,5). Anything else -> error=1,
//   valid=0, rest of word 0. OP needs funct7 0x00, or 0x20 with funct3 0/5; OP-IMM
//   shifts need imm[11:5] 0x00 (0x20 allowed for funct3 5 only).
//  alu_op = {funct7[5] (R-type / SRAI), funct3}; LUI/AUIPC/LOAD use 4'b0000 (ADD).
//  Operands: OP op1=rs1,op2=rs2; OP-IMM/LOAD op1=rs1,op2=sext I-imm; LUI op1=0,
//   op2={imm[31:12],12'b0}; AUIPC op1=pc, op2=U-imm.
//  Register operand select, priority: rs==0 -> 0 ready; rsX_valid -> sX; forwarding_addr==rs
//   -> forwarding; else value 0, not ready. ops_ready = AND over used register operands.
//  Intra-pair hazard: B source equal to rdA while map_en_A=1 -> that operand not ready,
//   overriding rsB_valid and forwarding.
//  reg_we = map_en = legal && writes rd && rd!=0. rs*/rd* are raw fields regardless of legality.
//  Latency: decoded_inst*/error_* update one cycle after inputs; no stall/handshake, new pair each cycle.
//  Reset: decoded_instA/B=0, error_A/B=0 on the reset edge; combinational outputs unaffected.
//  Reset mid-stream: the pair presented during reset is discarded.
// CONFIGURATION
//  DECODER_FORWARD_EN defined: forwarding-bus bypass as above.
//  Undefined: forwarding/forwarding_addr ignored; operand ready only via rs==0 or rsX_valid.
// STRUCTURE
//  decoder_pkg: opcode constants, fu codes, alu_op codes, decoded-word bit offsets/width 83.
//  Sub-module decode_slot (one instruction + operand select), instantiated twice;
//   top adds the A->B hazard check and output registers.
// TESTING
//  1 instA=0x00000013, pcA=0x10 -> next cycle valid=1, rd=0, reg_we=0, map_en_A=0, error_A=0, op1=op2=0, ready=1.
//  2 instA=0x00208093 (addi x1,x1,2), rs1A_valid=0, forwarding_addr=1, forwarding=0x55555555
//    -> rs1A=1, rdA=1, map_en_A=1; op1=0x55555555, op2=2, ready=1; with addr=2 -> ready=0.
//  3 instA=0xDEADBEEF, instB=0xCAFEBABE (also 0x13579BDF) -> error=1, valid=0.
//  4 instA=0x002081B3 (add x3,x1,x2), instB=0x40118233 (sub x4,x3,x1), all valid=1
//    -> B alu_op=4'b1000, B ready=0; A ready=1, A op1=s1A, A op2=s2A.
//  5 instA=0x00001097 (auipc x1,1), pcA=0x40 -> op1=0x40, op2=0x1000, fu=ALU.
//  6 rst=1 one cycle mid-stream -> decoded_inst*=0, error_*=0 after that edge; normal next cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and types for the dual-issue RV32I decode stage.
// Holds the RV32I opcodes we accept, functional-unit codes, the ALU opcode used
// for address/upper-immediate arithmetic, and the 83-bit decoded-word layout,
// given both as a packed struct and as bit offsets.
package decoder_pkg;

    localparam int DEC_W = 83;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MEM = 2'd1
    } fu_e;

    localparam int OFF_OPS_READY = 0;
    localparam int OFF_OP2       = 1;
    localparam int OFF_OP1       = 33;
    localparam int OFF_RD        = 65;
    localparam int OFF_FUNCT3    = 70;
    localparam int OFF_MEM_WE    = 73;
    localparam int OFF_MEM_RE    = 74;
    localparam int OFF_REG_WE    = 75;
    localparam int OFF_ALU_OP    = 76;
    localparam int OFF_FU        = 80;
    localparam int OFF_VALID     = 82;

    // Field order is MSB first and matches the offsets above.
    typedef struct packed {
        logic        valid;
        fu_e         fu;
        logic [3:0]  alu_op;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        ops_ready;
    } decoded_t;

endpackage

// File: rtl/dual_issue_decoder_if.sv
// dual_issue_decoder_if: bundles every non-clock signal of the dual-issue decoder.
//  inputs : instA/B, pcA/B, forwarding, forwarding_addr, s1A/s2A/s1B/s2B,
//           rs1A_valid..rs2B_valid
//  outputs: decoded_instA/B (registered), error_A/B (registered),
//           map_en_A/B, rs1A/rs2A/rs1B/rs2B, rdA/rdB (combinational)
// slave is the decoder side, master is the fetch/regfile/dispatch side.
interface dual_issue_decoder_if;

    logic [31:0] instA, instB;
    logic [31:0] pcA, pcB;
    logic [31:0] forwarding;
    logic [4:0]  forwarding_addr;
    logic [31:0] s1A, s2A, s1B, s2B;
    logic        rs1A_valid, rs2A_valid, rs1B_valid, rs2B_valid;

    logic [decoder_pkg::DEC_W-1:0] decoded_instA, decoded_instB;
    logic        map_en_A, map_en_B;
    logic [4:0]  rs1A, rs2A, rs1B, rs2B;
    logic [4:0]  rdA, rdB;
    logic        error_A, error_B;

    modport slave (
        input  instA, instB, pcA, pcB, forwarding, forwarding_addr,
               s1A, s2A, s1B, s2B, rs1A_valid, rs2A_valid, rs1B_valid, rs2B_valid,
        output decoded_instA, decoded_instB, map_en_A, map_en_B,
               rs1A, rs2A, rs1B, rs2B, rdA, rdB, error_A, error_B
    );

    modport master (
        output instA, instB, pcA, pcB, forwarding, forwarding_addr,
               s1A, s2A, s1B, s2B, rs1A_valid, rs2A_valid, rs1B_valid, rs2B_valid,
        input  decoded_instA, decoded_instB, map_en_A, map_en_B,
               rs1A, rs2A, rs1B, rs2B, rdA, rdB, error_A, error_B
    );

endinterface

// File: rtl/decode_slot.sv
// decode_slot: purely combinational decode of one RV32I instruction plus operand
// source selection (regfile, writeback bypass, immediate or PC).
// Configuration macro: DECODER_FORWARD_EN enables the writeback forwarding bypass;
// when undefined forwarding_i/forwarding_addr_i are ignored.
//  inst_i, pc_i            instruction and its PC
//  s1_i, s2_i              regfile read data, rs*_valid_i marks them up to date
//  forwarding_i/_addr_i    writeback bus and its destination register
//  rs1_block_i/rs2_block_i force the operand not ready (intra-pair hazard)
//  word_o                  decoded word (all zero when illegal)
//  error_o, map_en_o       illegal flag, rename allocate
//  rs1_o, rs2_o, rd_o      raw register fields
module decode_slot
    import decoder_pkg::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] s1_i,
    input  logic [31:0] s2_i,
    input  logic        rs1_valid_i,
    input  logic        rs2_valid_i,
    input  logic [31:0] forwarding_i,
    input  logic [4:0]  forwarding_addr_i,
    input  logic        rs1_block_i,
    input  logic        rs2_block_i,
    output decoded_t    word_o,
    output logic        error_o,
    output logic        map_en_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immI;
    logic [31:0] immU;
    logic        fwdHit1, fwdHit2;
    logic [32:0] src1, src2;
    logic        legal, usesRs1, usesRs2, isLoad;
    logic [3:0]  aluOp;
    logic [31:0] op1, op2;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd_o   = inst_i[11:7];
    assign rs1_o  = inst_i[19:15];
    assign rs2_o  = inst_i[24:20];
    assign immI   = {{20{inst_i[31]}}, inst_i[31:20]};
    assign immU   = {inst_i[31:12], 12'b0};

`ifdef DECODER_FORWARD_EN
    assign fwdHit1 = (forwarding_addr_i == rs1_o);
    assign fwdHit2 = (forwarding_addr_i == rs2_o);
`else
    logic unused_fwdAddr;
    assign unused_fwdAddr = ^forwarding_addr_i;
    assign fwdHit1 = 1'b0;
    assign fwdHit2 = 1'b0;
`endif

    // Returns {ready, value}. x0 always wins, then a hazard block, then the
    // regfile, then the bypass bus.
    function automatic logic [32:0] selectSrc(
        input logic [4:0]  rs,
        input logic        rsValid,
        input logic [31:0] regData,
        input logic        blocked,
        input logic        fwdHit,
        input logic [31:0] fwdData
    );
        if (rs == 5'd0)   return {1'b1, 32'd0};
        else if (blocked) return {1'b0, 32'd0};
        else if (rsValid) return {1'b1, regData};
        else if (fwdHit)  return {1'b1, fwdData};
        else              return {1'b0, 32'd0};
    endfunction

    assign src1 = selectSrc(rs1_o, rs1_valid_i, s1_i, rs1_block_i, fwdHit1, forwarding_i);
    assign src2 = selectSrc(rs2_o, rs2_valid_i, s2_i, rs2_block_i, fwdHit2, forwarding_i);

    // Opcode decode: legality, operand sources and ALU opcode. funct7[5]
    // only reaches alu_op for SUB/SRA and SRAI.
    always_comb begin
        legal   = 1'b0;
        usesRs1 = 1'b0;
        usesRs2 = 1'b0;
        isLoad  = 1'b0;
        aluOp   = ALU_ADD;
        op1     = 32'd0;
        op2     = 32'd0;
        case (opcode)
            OPC_OP: begin
                legal   = (funct7 == F7_BASE) ||
                          ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                aluOp   = {funct7[5], funct3};
                op1     = src1[31:0];
                op2     = src2[31:0];
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'd1:    legal = (funct7 == F7_BASE);
                    3'd5:    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
                usesRs1 = 1'b1;
                aluOp   = {(funct3 == 3'd5) && funct7[5], funct3};
                op1     = src1[31:0];
                op2     = immI;
            end
            OPC_LUI: begin
                legal = 1'b1;
                op2   = immU;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op1   = pc_i;
                op2   = immU;
            end
            OPC_LOAD: begin
                legal   = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
                usesRs1 = 1'b1;
                isLoad  = 1'b1;
                op1     = src1[31:0];
                op2     = immI;
            end
            default: ;
        endcase
    end

    assign map_en_o = legal && (rd_o != 5'd0);
    assign error_o  = !legal;

    // Illegal instructions leave the whole word zero so dispatch sees valid=0.
    always_comb begin
        word_o = '0;
        if (legal) begin
            word_o.valid     = 1'b1;
            word_o.fu        = isLoad ? FU_MEM : FU_ALU;
            word_o.alu_op    = aluOp;
            word_o.reg_we    = map_en_o;
            word_o.mem_re    = isLoad;
            word_o.mem_we    = 1'b0;
            word_o.funct3    = funct3;
            word_o.rd        = rd_o;
            word_o.op1       = op1;
            word_o.op2       = op2;
            word_o.ops_ready = (!usesRs1 || src1[32]) && (!usesRs2 || src2[32]);
        end
    end

endmodule

// File: rtl/dual_issue_decoder.sv
// dual_issue_decoder: two-slot (A older, B younger) RV32I decode stage.
// Configuration macro: DECODER_FORWARD_EN (forwarding bypass, see decode_slot).
//  clk  rising-edge clock
//  rst  synchronous active-high reset of the registered outputs
//  bus  dual_issue_decoder_if.slave: instructions, PCs, regfile data/valids and
//       the writeback bus in; registered decoded words/errors and combinational
//       register addresses/map enables out.
module dual_issue_decoder
    import decoder_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    dual_issue_decoder_if.slave bus
);

    decoded_t          decodedA_d, decodedB_d;
    logic              errorA_d, errorB_d;
    logic [DEC_W-1:0]  decodedA_q, decodedB_q;
    logic              errorA_q, errorB_q;
    logic              mapEnA, mapEnB;
    logic [4:0]        rs1A, rs2A, rs1B, rs2B, rdA, rdB;
    logic              hazB1, hazB2;

    decode_slot slotA (
        .inst_i            (bus.instA),
        .pc_i              (bus.pcA),
        .s1_i              (bus.s1A),
        .s2_i              (bus.s2A),
        .rs1_valid_i       (bus.rs1A_valid),
        .rs2_valid_i       (bus.rs2A_valid),
        .forwarding_i      (bus.forwarding),
        .forwarding_addr_i (bus.forwarding_addr),
        .rs1_block_i       (1'b0),
        .rs2_block_i       (1'b0),
        .word_o            (decodedA_d),
        .error_o           (errorA_d),
        .map_en_o          (mapEnA),
        .rs1_o             (rs1A),
        .rs2_o             (rs2A),
        .rd_o              (rdA)
    );

    // B cannot see A's result this cycle: any B source that A is about to
    // rename is not ready, no matter what the regfile or bypass says.
    assign hazB1 = mapEnA && (rs1B == rdA);
    assign hazB2 = mapEnA && (rs2B == rdA);

    decode_slot slotB (
        .inst_i            (bus.instB),
        .pc_i              (bus.pcB),
        .s1_i              (bus.s1B),
        .s2_i              (bus.s2B),
        .rs1_valid_i       (bus.rs1B_valid),
        .rs2_valid_i       (bus.rs2B_valid),
        .forwarding_i      (bus.forwarding),
        .forwarding_addr_i (bus.forwarding_addr),
        .rs1_block_i       (hazB1),
        .rs2_block_i       (hazB2),
        .word_o            (decodedB_d),
        .error_o           (errorB_d),
        .map_en_o          (mapEnB),
        .rs1_o             (rs1B),
        .rs2_o             (rs2B),
        .rd_o              (rdB)
    );

    // Output register: a pair presented while rst is high is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            decodedA_q <= '0;
            decodedB_q <= '0;
            errorA_q   <= 1'b0;
            errorB_q   <= 1'b0;
        end else begin
            decodedA_q <= decodedA_d;
            decodedB_q <= decodedB_d;
            errorA_q   <= errorA_d;
            errorB_q   <= errorB_d;
        end
    end

    assign bus.decoded_instA = decodedA_q;
    assign bus.decoded_instB = decodedB_q;
    assign bus.error_A       = errorA_q;
    assign bus.error_B       = errorB_q;
    assign bus.map_en_A      = mapEnA;
    assign bus.map_en_B      = mapEnB;
    assign bus.rs1A          = rs1A;
    assign bus.rs2A          = rs2A;
    assign bus.rs1B          = rs1B;
    assign bus.rs2B          = rs2B;
    assign bus.rdA           = rdA;
    assign bus.rdB           = rdB;

endmodule

// File: tb/tb_dual_issue_decoder.sv
// tb_dual_issue_decoder: directed and table-driven bench for dual_issue_decoder.
// A spec-level model predicts every output each cycle; directed steps also pin
// hand-computed literals. Honors DECODER_FORWARD_EN like the design.
module tb_dual_issue_decoder;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    dual_issue_decoder_if dif();

    dual_issue_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [82:0] word;
        logic        err;
        logic        mapEn;
    } slotExp_t;

    // One register source as the pipeline sees it: {ready, value}.
    function automatic logic [32:0] modelReg(
        input logic [4:0] r, input logic v, input logic [31:0] s,
        input logic [4:0] hazRd, input logic hazOn,
        input logic [4:0] fAddr, input logic [31:0] fData
    );
        logic [32:0] res;
        res = 33'h0;
        if (r == 5'd0) res = {1'b1, 32'h0};
        else if (hazOn && r == hazRd) res = 33'h0;
        else if (v) res = {1'b1, s};
`ifdef DECODER_FORWARD_EN
        else if (fAddr == r) res = {1'b1, fData};
`endif
        return res;
    endfunction

    function automatic slotExp_t modelSlot(
        input logic [31:0] inst, input logic [31:0] pc,
        input logic [31:0] s1, input logic [31:0] s2,
        input logic v1, input logic v2,
        input logic [4:0] hazRd, input logic hazOn,
        input logic [4:0] fAddr, input logic [31:0] fData
    );
        slotExp_t    e;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        ok, mem, u1, u2;
        logic [3:0]  alu;
        logic [31:0] a, b;
        logic [32:0] r1, r2;
        logic        rdy;
        f7 = inst[31:25]; f3 = inst[14:12]; rd = inst[11:7];
        ok = 1'b0; mem = 1'b0; u1 = 1'b0; u2 = 1'b0; alu = 4'd0; a = 32'd0; b = 32'd0;
        r1 = modelReg(inst[19:15], v1, s1, hazRd, hazOn, fAddr, fData);
        r2 = modelReg(inst[24:20], v2, s2, hazRd, hazOn, fAddr, fData);
        case (inst[6:0])
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                u1 = 1'b1; u2 = 1'b1; a = r1[31:0]; b = r2[31:0];
                alu = (f7 == 7'h20) ? 4'd8 + 4'(f3) : 4'(f3);
            end
            7'h13: begin
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                else ok = 1'b1;
                u1 = 1'b1; a = r1[31:0]; b = 32'(signed'(inst[31:20]));
                alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd13 : 4'(f3);
            end
            7'h37: begin ok = 1'b1; b = inst & 32'hFFFFF000; end
            7'h17: begin ok = 1'b1; a = pc; b = inst & 32'hFFFFF000; end
            7'h03: begin
                ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
                mem = 1'b1; u1 = 1'b1; a = r1[31:0]; b = 32'(signed'(inst[31:20]));
            end
            default: ok = 1'b0;
        endcase
        rdy = (!u1 || r1[32]) && (!u2 || r2[32]);
        e.mapEn = ok && (rd != 5'd0);
        e.err   = !ok;
        e.word  = ok ? {1'b1, mem ? 2'd1 : 2'd0, alu, e.mapEn, mem, 1'b0, f3, rd, a, b, rdy} : 83'h0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [82:0] act, input logic [82:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else passes++;
    endtask

    task automatic applyStimulus(input logic [31:0] iA, input logic [31:0] iB,
                                 input logic [31:0] pA, input logic [31:0] pB);
        dif.instA = iA; dif.instB = iB; dif.pcA = pA; dif.pcB = pB;
    endtask

    task automatic setRegs(input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] b1, input logic [31:0] b2, input logic [3:0] v);
        dif.s1A = a1; dif.s2A = a2; dif.s1B = b1; dif.s2B = b2;
        {dif.rs1A_valid, dif.rs2A_valid, dif.rs1B_valid, dif.rs2B_valid} = v;
    endtask

    // Model state for the registered outputs, captured at each rising edge.
    logic        expValid = 1'b0;
    logic [82:0] expWA, expWB;
    logic        expEA, expEB;

    function automatic slotExp_t curA();
        return modelSlot(dif.instA, dif.pcA, dif.s1A, dif.s2A, dif.rs1A_valid, dif.rs2A_valid,
                         5'd0, 1'b0, dif.forwarding_addr, dif.forwarding);
    endfunction

    function automatic slotExp_t curB(input slotExp_t a);
        return modelSlot(dif.instB, dif.pcB, dif.s1B, dif.s2B, dif.rs1B_valid, dif.rs2B_valid,
                         dif.instA[11:7], a.mapEn, dif.forwarding_addr, dif.forwarding);
    endfunction

    always @(posedge clk) begin
        slotExp_t a, b;
        a = curA();
        b = curB(a);
        expValid <= expValid | rst;
        expWA <= rst ? 83'h0 : a.word;
        expWB <= rst ? 83'h0 : b.word;
        expEA <= rst ? 1'b0 : a.err;
        expEB <= rst ? 1'b0 : b.err;
    end

    always @(negedge clk) begin
        slotExp_t a, b;
        if (expValid) begin
            a = curA();
            b = curB(a);
            checkOutput("cyc_wordA", dif.decoded_instA, expWA);
            checkOutput("cyc_wordB", dif.decoded_instB, expWB);
            checkOutput("cyc_errAB", 83'({dif.error_A, dif.error_B}), 83'({expEA, expEB}));
            checkOutput("cyc_comb",
                83'({dif.map_en_A, dif.map_en_B, dif.rs1A, dif.rs2A, dif.rs1B, dif.rs2B, dif.rdA, dif.rdB}),
                83'({a.mapEn, b.mapEn, dif.instA[19:15], dif.instA[24:20], dif.instB[19:15],
                     dif.instB[24:20], dif.instA[11:7], dif.instB[11:7]}));
        end
    end

    logic [31:0] pool [12] = '{32'h00000013, 32'h00208093, 32'h002081B3, 32'h40118233,
                               32'h4030D093, 32'h40309093, 32'hFFC12283, 32'h00013283,
                               32'h123450B7, 32'h00001097, 32'hDEADBEEF, 32'h0010A133};

    initial begin
        rst = 1'b1;
        applyStimulus(32'h13, 32'h13, 32'h0, 32'h4);
        setRegs(32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        dif.forwarding = 32'h0; dif.forwarding_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wordA", dif.decoded_instA, 83'h0);
        checkOutput("rst_errA", 83'(dif.error_A), 83'h0);
        rst = 1'b0;

        // nop: legal, writes x0
        applyStimulus(32'h00000013, 32'h00000013, 32'h10, 32'h14);
        @(posedge clk); #1;
        checkOutput("t1_wordA", dif.decoded_instA,
                    {1'b1, 2'd0, 4'd0, 3'b000, 3'd0, 5'd0, 32'd0, 32'd0, 1'b1});
        checkOutput("t1_mapA_errA", 83'({dif.map_en_A, dif.error_A}), 83'h0);

        // addi x1,x1,2 with rs1 only on the bypass bus
        dif.forwarding = 32'h55555555; dif.forwarding_addr = 5'd1;
        applyStimulus(32'h00208093, 32'h00000013, 32'h20, 32'h24);
        @(posedge clk); #1;
        checkOutput("t2_comb", 83'({dif.rs1A, dif.rdA, dif.map_en_A}), 83'({5'd1, 5'd1, 1'b1}));
        checkOutput("t2_op2", 83'(dif.decoded_instA[32:1]), 83'(32'd2));
`ifdef DECODER_FORWARD_EN
        checkOutput("t2_op1", 83'(dif.decoded_instA[64:33]), 83'(32'h55555555));
        checkOutput("t2_ready", 83'(dif.decoded_instA[0]), 83'd1);
`else
        checkOutput("t2_op1", 83'(dif.decoded_instA[64:33]), 83'd0);
        checkOutput("t2_ready", 83'(dif.decoded_instA[0]), 83'd0);
`endif
        dif.forwarding_addr = 5'd2;
        @(posedge clk); #1;
        checkOutput("t2_ready_miss", 83'(dif.decoded_instA[0]), 83'd0);

        // unsupported opcodes
        applyStimulus(32'hDEADBEEF, 32'hCAFEBABE, 32'h30, 32'h34);
        @(posedge clk); #1;
        checkOutput("t3_err", 83'({dif.error_A, dif.error_B}), 83'b11);
        checkOutput("t3_wordA", dif.decoded_instA, 83'h0);
        checkOutput("t3_wordB", dif.decoded_instB, 83'h0);
        dif.instB = 32'h13579BDF;
        @(posedge clk); #1;
        checkOutput("t3b_errB", 83'({dif.error_B, dif.decoded_instB[82]}), 83'b10);

        // add x3,x1,x2 ; sub x4,x3,x1 -> B rs1 depends on A
        setRegs(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'b1111);
        applyStimulus(32'h002081B3, 32'h40118233, 32'h40, 32'h44);
        @(posedge clk); #1;
        checkOutput("t4_aluB", 83'(dif.decoded_instB[79:76]), 83'(4'b1000));
        checkOutput("t4_readyB", 83'(dif.decoded_instB[0]), 83'd0);
        checkOutput("t4_readyA", 83'(dif.decoded_instA[0]), 83'd1);
        checkOutput("t4_opsA", 83'(dif.decoded_instA[64:1]), 83'({32'h11111111, 32'h22222222}));

        // auipc x1,1 ; lui x2,0x12345
        applyStimulus(32'h00001097, 32'h12345137, 32'h40, 32'h44);
        @(posedge clk); #1;
        checkOutput("t5_opsA", 83'(dif.decoded_instA[64:1]), 83'({32'h40, 32'h1000}));
        checkOutput("t5_fuA", 83'(dif.decoded_instA[81:80]), 83'd0);
        checkOutput("t5_op2B", 83'(dif.decoded_instB[32:1]), 83'(32'h12345000));

        // srai x1,x1,3 ; lw x5,-4(x2)
        applyStimulus(32'h4030D093, 32'hFFC12283, 32'h50, 32'h54);
        @(posedge clk); #1;
        checkOutput("t7_aluA", 83'(dif.decoded_instA[79:76]), 83'(4'b1101));
        checkOutput("t7_ldB", 83'({dif.decoded_instB[81:80], dif.decoded_instB[74], dif.decoded_instB[32:1]}),
                    83'({2'd1, 1'b1, 32'hFFFFFFFC}));

        // slli with funct7 0x20 and ld are both unsupported
        applyStimulus(32'h40309093, 32'h00013283, 32'h60, 32'h64);
        @(posedge clk); #1;
        checkOutput("t8_err", 83'({dif.error_A, dif.error_B}), 83'b11);

        // reset mid-stream drops the presented pair
        rst = 1'b1;
        applyStimulus(32'hDEADBEEF, 32'h002081B3, 32'h70, 32'h74);
        @(posedge clk); #1;
        checkOutput("t6_words", 83'(dif.decoded_instA | dif.decoded_instB), 83'h0);
        checkOutput("t6_err", 83'({dif.error_A, dif.error_B}), 83'h0);
        rst = 1'b0;
        applyStimulus(32'h00000013, 32'hDEADBEEF, 32'h80, 32'h84);
        @(posedge clk); #1;
        checkOutput("t6_after", 83'({dif.decoded_instA[82], dif.error_A, dif.error_B}), 83'b101);

        // table-driven pairs, cross-checked by the per-cycle model
        for (int i = 0; i < 30; i++) begin
            setRegs($urandom, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)));
            dif.forwarding      = $urandom;
            dif.forwarding_addr = 5'($urandom_range(0, 5));
            applyStimulus(pool[$urandom_range(0, 11)], pool[$urandom_range(0, 11)],
                          $urandom, $urandom);
            @(posedge clk); #1;
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
